// File: rtl/multi_window_timing_pkg.sv
// Shared types and helpers for the multi-window raster timing source.
// win_cfg_t holds one window's geometry; its fields are COORD_W bits wide,
// so the top-level CW parameter must equal COORD_W.
package multi_window_timing_pkg;

  localparam int COORD_W = 12;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
  } win_cfg_t;

  // Total period of a line or frame: active + front porch + sync + back porch.
  function automatic int unsigned period_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/window_compare.sv
// Rectangle decode for one window. The de_full input is the enable-qualified
// active-area term for the current counters. The output de is registered,
// so it lines up with the top-level registered outputs.
// With WIN_PRIORITY_EN defined, the unregistered hit is also exported so that
// the top can register the priority encoder alongside de.
module window_compare
  import multi_window_timing_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hcnt,
  input  logic [COORD_W-1:0] vcnt,
  input  logic               de_full,
  input  win_cfg_t           cfg,
`ifdef WIN_PRIORITY_EN
  output logic               de_next,
`endif
  output logic               de
);

  logic [COORD_W:0] right;
  logic [COORD_W:0] bottom;
  logic             in_x;
  logic             in_y;
  logic             hit;

  // The extra bit keeps left+width and top+height from wrapping. A zero size gives an empty range.
  assign right  = {1'b0, cfg.left} + {1'b0, cfg.width};
  assign bottom = {1'b0, cfg.top} + {1'b0, cfg.height};
  assign in_x   = (hcnt >= cfg.left) && ({1'b0, hcnt} < right);
  assign in_y   = (vcnt >= cfg.top) && ({1'b0, vcnt} < bottom);
  assign hit    = de_full && cfg.en && in_x && in_y;

`ifdef WIN_PRIORITY_EN
  assign de_next = hit;
`endif

  // Register the window hit so that it aligns with de_full and x_pos/y_pos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) de <= 1'b0;
    else        de <= hit;
  end

endmodule

// File: rtl/multi_window_timing.sv
// Raster timing generator with NWIN independently decoded rectangular windows.
// It owns the h/v counters, the sync and active decode, the frame-atomic
// double buffer of window geometry and, optionally, the priority encoder.
// Optional feature macro: WIN_PRIORITY_EN adds the win_hit and win_id outputs.
module multi_window_timing
  import multi_window_timing_pkg::*;
#(
  parameter int NWIN     = 4,
  parameter int CW       = COORD_W,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int SYNC_POL = 1
) (
  input  logic               pclk,
  input  logic               prst_n,
  input  logic               enable,
  input  logic               cfg_valid,
  input  logic [NWIN-1:0]    cfg_win_en,
  input  logic [NWIN*CW-1:0] cfg_top,
  input  logic [NWIN*CW-1:0] cfg_left,
  input  logic [NWIN*CW-1:0] cfg_width,
  input  logic [NWIN*CW-1:0] cfg_height,
  output logic               vs,
  output logic               hs,
  output logic               de_full,
  output logic [NWIN-1:0]    de,
  output logic [CW-1:0]      x_pos,
  output logic [CW-1:0]      y_pos,
`ifdef WIN_PRIORITY_EN
  output logic               win_hit,
  output logic [((NWIN > 1) ? $clog2(NWIN) : 1)-1:0] win_id,
`endif
  output logic               sof
);

  localparam int unsigned HTOT = period_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTOT = period_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_LAST    = CW'(HTOT - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(VTOT - 1);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          last_pix;
  logic          active_c;
  logic          hsync_c;
  logic          vsync_c;
  logic          sof_c;
  logic          load_active;

  win_cfg_t bus_cfg [NWIN];
  win_cfg_t pend_cfg[NWIN];
  win_cfg_t act_cfg [NWIN];

  // All decode terms include enable so that a disabled core drives reset levels next cycle.
  assign last_pix    = (hcnt == H_LAST) && (vcnt == V_LAST);
  assign active_c    = enable && (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
  assign hsync_c     = enable && (hcnt >= HS_START) && (hcnt < HS_END);
  assign vsync_c     = enable && (vcnt >= VS_START) && (vcnt < VS_END);
  assign sof_c       = enable && (hcnt == '0) && (vcnt == '0);
  assign load_active = !enable || last_pix;

  // Pixel and line counters, held at (0,0) while disabled.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Registered raster outputs, one cycle behind the counters they decode.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      vs      <= ~SYNC_ON;
      hs      <= ~SYNC_ON;
      de_full <= 1'b0;
      x_pos   <= '0;
      y_pos   <= '0;
      sof     <= 1'b0;
    end else begin
      vs      <= vsync_c ? SYNC_ON : ~SYNC_ON;
      hs      <= hsync_c ? SYNC_ON : ~SYNC_ON;
      de_full <= active_c;
      x_pos   <= active_c ? hcnt : '0;
      y_pos   <= active_c ? vcnt : '0;
      sof     <= sof_c;
    end
  end

  // Unpack the flat configuration bus into per-window records.
  for (genvar g = 0; g < NWIN; g++) begin : g_bus
    assign bus_cfg[g] = '{en:     cfg_win_en[g],
                          top:    cfg_top   [g*CW +: CW],
                          left:   cfg_left  [g*CW +: CW],
                          width:  cfg_width [g*CW +: CW],
                          height: cfg_height[g*CW +: CW]};
  end

  // Pending set: holds the most recent strobe until the next frame boundary.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int i = 0; i < NWIN; i++) pend_cfg[i] <= '0;
    end else if (cfg_valid) begin
      pend_cfg <= bus_cfg;
    end
  end

  // Active set: swapped only on the last pixel of a frame or while idle; a strobe on that cycle wins.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int i = 0; i < NWIN; i++) act_cfg[i] <= '0;
    end else if (load_active) begin
      act_cfg <= cfg_valid ? bus_cfg : pend_cfg;
    end
  end

`ifdef WIN_PRIORITY_EN
  localparam int IDW = (NWIN > 1) ? $clog2(NWIN) : 1;
  logic [NWIN-1:0] de_next;
  logic [IDW-1:0]  id_c;
`endif

  for (genvar g = 0; g < NWIN; g++) begin : g_win
    window_compare u_win (
      .clk     (pclk),
      .rst_n   (prst_n),
      .hcnt    (hcnt),
      .vcnt    (vcnt),
      .de_full (active_c),
      .cfg     (act_cfg[g]),
`ifdef WIN_PRIORITY_EN
      .de_next (de_next[g]),
`endif
      .de      (de[g])
    );
  end

`ifdef WIN_PRIORITY_EN
  // Lowest-index hit wins; scanning downward leaves the smallest index in id_c.
  always_comb begin
    id_c = '0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      if (de_next[i]) id_c = IDW'(i);
    end
  end

  // Register the priority result so that it stays aligned with de.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      win_hit <= 1'b0;
      win_id  <= '0;
    end else begin
      win_hit <= |de_next;
      win_id  <= id_c;
    end
  end
`endif

endmodule

// File: tb/tb_multi_window_timing.sv
// Bench for multi_window_timing with a small raster (24x12 totals, 16x8 active) and two windows.
// A position-based reference model predicts every output each cycle, and directed frame
// statistics pin the model with hand-computed pixel counts and extents.
// Build with WIN_PRIORITY_EN defined to cover win_hit/win_id as well.
module tb_multi_window_timing;
  import multi_window_timing_pkg::*;

  localparam int NWIN = 2;
  localparam int CW   = COORD_W;
  localparam int HA = 16, HFP = 2, HSY = 2, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSY = 1, VBP = 2;
  localparam int HTOT = 24, VTOT = 12, FTOT = HTOT * VTOT;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic cfg_valid = 1'b0;
  logic [NWIN-1:0]    cfg_win_en = '0;
  logic [NWIN*CW-1:0] cfg_top = '0, cfg_left = '0, cfg_width = '0, cfg_height = '0;
  logic vs, hs, de_full, sof;
  logic [NWIN-1:0] de;
  logic [CW-1:0]   x_pos, y_pos;
`ifdef WIN_PRIORITY_EN
  logic       win_hit;
  logic [0:0] win_id;
`endif

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  multi_window_timing #(
    .NWIN(NWIN), .CW(CW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1)
  ) dut (
    .pclk(clk), .prst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_win_en(cfg_win_en), .cfg_top(cfg_top), .cfg_left(cfg_left),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .vs(vs), .hs(hs), .de_full(de_full), .de(de), .x_pos(x_pos), .y_pos(y_pos),
`ifdef WIN_PRIORITY_EN
    .win_hit(win_hit), .win_id(win_id),
`endif
    .sof(sof)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a flat frame position plus pending/active window tables.
  int mpos;
  int pe[NWIN], pt[NWIN], pl[NWIN], pw[NWIN], ph[NWIN];
  int ae[NWIN], at[NWIN], al[NWIN], aw[NWIN], ah[NWIN];
  logic exp_vs = 1'b0, exp_hs = 1'b0, exp_full = 1'b0, exp_sof = 1'b0, exp_hit = 1'b0;
  logic [NWIN-1:0] exp_de = '0;
  logic [CW-1:0]   exp_x = '0, exp_y = '0;
  logic [0:0]      exp_id = '0;

  // Advance the model on each clock; predictions are for the outputs after this edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mpos = 0;
      for (int i = 0; i < NWIN; i++) begin
        pe[i] = 0; pt[i] = 0; pl[i] = 0; pw[i] = 0; ph[i] = 0;
        ae[i] = 0; at[i] = 0; al[i] = 0; aw[i] = 0; ah[i] = 0;
      end
      exp_vs = 0; exp_hs = 0; exp_full = 0; exp_sof = 0; exp_de = '0;
      exp_x = '0; exp_y = '0; exp_hit = 0; exp_id = '0;
    end else begin
      int x, y;
      x = mpos % HTOT;
      y = mpos / HTOT;
      if (enable) begin
        exp_full = (x < HA) && (y < VA);
        exp_hs   = (x >= HA + HFP) && (x < HA + HFP + HSY);
        exp_vs   = (y >= VA + VFP) && (y < VA + VFP + VSY);
        exp_sof  = (mpos == 0);
        exp_x    = exp_full ? CW'(x) : '0;
        exp_y    = exp_full ? CW'(y) : '0;
        for (int i = 0; i < NWIN; i++)
          exp_de[i] = exp_full && (ae[i] != 0) && (x >= al[i]) && (x < al[i] + aw[i])
                      && (y >= at[i]) && (y < at[i] + ah[i]);
      end else begin
        exp_full = 0; exp_hs = 0; exp_vs = 0; exp_sof = 0;
        exp_x = '0; exp_y = '0; exp_de = '0;
      end
      exp_hit = |exp_de;
      exp_id  = (!exp_de[0] && exp_de[1]) ? 1'b1 : 1'b0;
      if (cfg_valid) begin
        for (int i = 0; i < NWIN; i++) begin
          pe[i] = int'(cfg_win_en[i]);
          pt[i] = int'(cfg_top[i*CW +: CW]);
          pl[i] = int'(cfg_left[i*CW +: CW]);
          pw[i] = int'(cfg_width[i*CW +: CW]);
          ph[i] = int'(cfg_height[i*CW +: CW]);
        end
      end
      if (!enable || mpos == FTOT - 1) begin
        ae = pe; at = pt; al = pl; aw = pw; ah = ph;
      end
      mpos = enable ? (mpos + 1) % FTOT : 0;
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("vs", vs, exp_vs);
      checkOutput("hs", hs, exp_hs);
      checkOutput("de_full", de_full, exp_full);
      checkOutput("de", de, exp_de);
      checkOutput("x_pos", x_pos, exp_x);
      checkOutput("y_pos", y_pos, exp_y);
      checkOutput("sof", sof, exp_sof);
`ifdef WIN_PRIORITY_EN
      checkOutput("win_hit", win_hit, exp_hit);
      checkOutput("win_id", win_id, exp_id);
`endif
    end
  end

  // Frame statistics gathered from the DUT for the hand-computed literal checks.
  int cnt_full, cnt_hs, cnt_vs, cnt_sof, cnt0, cnt1, cnt_ov0, cnt_id1, cnt_hit;
  int minx0, maxx0, miny0, maxy0, minx1, maxx1, miny1, maxy1;

  task automatic clearStats();
    cnt_full = 0; cnt_hs = 0; cnt_vs = 0; cnt_sof = 0; cnt0 = 0; cnt1 = 0;
    cnt_ov0 = 0; cnt_id1 = 0; cnt_hit = 0;
    minx0 = 9999; maxx0 = -1; miny0 = 9999; maxy0 = -1;
    minx1 = 9999; maxx1 = -1; miny1 = 9999; maxy1 = -1;
  endtask

  // Accumulate DUT output statistics each falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (de_full) cnt_full++;
      if (hs) cnt_hs++;
      if (vs) cnt_vs++;
      if (sof) cnt_sof++;
      if (de[0]) begin
        cnt0++;
        if (int'(x_pos) < minx0) minx0 = int'(x_pos);
        if (int'(x_pos) > maxx0) maxx0 = int'(x_pos);
        if (int'(y_pos) < miny0) miny0 = int'(y_pos);
        if (int'(y_pos) > maxy0) maxy0 = int'(y_pos);
      end
      if (de[1]) begin
        cnt1++;
        if (int'(x_pos) < minx1) minx1 = int'(x_pos);
        if (int'(x_pos) > maxx1) maxx1 = int'(x_pos);
        if (int'(y_pos) < miny1) miny1 = int'(y_pos);
        if (int'(y_pos) > maxy1) maxy1 = int'(y_pos);
      end
`ifdef WIN_PRIORITY_EN
      if (win_hit) cnt_hit++;
      if (de == 2'b11 && win_hit && win_id == 1'b0) cnt_ov0++;
      if (win_hit && win_id == 1'b1) cnt_id1++;
`endif
    end
  end

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Step until the DUT shows sof; a missing sof within the bound is a failure.
  task automatic syncFrame();
    bit found = 1'b0;
    for (int k = 0; k < FTOT + 20; k++) begin
      @(negedge clk);
      #1;
      if (sof === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("sof_seen", found, 1'b1);
  endtask

  // Drive both windows onto the bus and pulse cfg_valid for one cycle.
  task automatic applyStimulus(input logic [1:0] en,
                               input int t0, input int l0, input int w0, input int h0,
                               input int t1, input int l1, input int w1, input int h1);
    cfg_win_en = en;
    cfg_top    = {CW'(t1), CW'(t0)};
    cfg_left   = {CW'(l1), CW'(l0)};
    cfg_width  = {CW'(w1), CW'(w0)};
    cfg_height = {CW'(h1), CW'(h0)};
    cfg_valid  = 1'b1;
    @(negedge clk);
    #1;
    cfg_valid  = 1'b0;
  endtask

  initial begin
    checking = 1'b1;
    #2 rst_n = 1'b0;
    runCycles(3);
    checkOutput("rst_vs", vs, 1'b0);
    checkOutput("rst_hs", hs, 1'b0);
    checkOutput("rst_de", de, 2'b00);
    checkOutput("rst_x", x_pos, 12'd0);

    // 1: free-running raster with no windows configured
    rst_n = 1'b1;
    enable = 1'b1;
    runCycles(1);
    checkOutput("first_sof", sof, 1'b1);
    checkOutput("first_full", de_full, 1'b1);
    clearStats();
    runCycles(FTOT);
    checkOutput("frame_full", cnt_full, 128);
    checkOutput("frame_hs", cnt_hs, 24);
    checkOutput("frame_vs", cnt_vs, 24);
    checkOutput("frame_sof", cnt_sof, 1);
    checkOutput("frame_de0_off", cnt0, 0);

    // 2: window 0 at top 2, left 3, 4x3
    applyStimulus(2'b01, 2, 3, 4, 3, 0, 0, 0, 0);
    runCycles(FTOT + 10);
    clearStats();
    runCycles(FTOT);
    checkOutput("w0_count", cnt0, 12);
    checkOutput("w0_minx", minx0, 3);
    checkOutput("w0_maxx", maxx0, 6);
    checkOutput("w0_miny", miny0, 2);
    checkOutput("w0_maxy", maxy0, 4);

    // 3: window 1 runs past the active area and is clipped; then zero width
    applyStimulus(2'b11, 2, 3, 4, 3, 6, 14, 5, 5);
    runCycles(FTOT + 10);
    clearStats();
    runCycles(FTOT);
    checkOutput("w1_count", cnt1, 4);
    checkOutput("w1_minx", minx1, 14);
    checkOutput("w1_maxx", maxx1, 15);
    checkOutput("w1_miny", miny1, 6);
    checkOutput("w1_maxy", maxy1, 7);
    applyStimulus(2'b11, 2, 3, 4, 3, 6, 14, 0, 5);
    runCycles(FTOT + 10);
    clearStats();
    runCycles(FTOT);
    checkOutput("w1_zero_width", cnt1, 0);

    // 4: mid-frame move of window 0 to left 8 takes effect only in the next frame
    syncFrame();
    runCycles(60);
    applyStimulus(2'b01, 2, 8, 4, 3, 0, 0, 0, 0);
    clearStats();
    runCycles(226);
    checkOutput("move_cur_count", cnt0, 8);
    checkOutput("move_cur_minx", minx0, 3);
    checkOutput("move_cur_maxx", maxx0, 6);
    clearStats();
    runCycles(FTOT);
    checkOutput("move_next_count", cnt0, 12);
    checkOutput("move_next_minx", minx0, 8);
    checkOutput("move_next_maxx", maxx0, 11);

    // 4b: strobe on the last pixel of the frame applies to the very next frame
    syncFrame();
    runCycles(286);
    applyStimulus(2'b01, 2, 0, 4, 3, 0, 0, 0, 0);
    clearStats();
    runCycles(FTOT);
    checkOutput("bnd_count", cnt0, 12);
    checkOutput("bnd_minx", minx0, 0);
    checkOutput("bnd_maxx", maxx0, 3);

    // 5: enable low mid-line returns outputs to reset levels; re-enable restarts at (0,0)
    syncFrame();
    runCycles(30);
    enable = 1'b0;
    runCycles(1);
    checkOutput("dis_full", de_full, 1'b0);
    checkOutput("dis_x", x_pos, 12'd0);
    runCycles(4);
    enable = 1'b1;
    runCycles(1);
    checkOutput("reen_sof", sof, 1'b1);
    checkOutput("reen_full", de_full, 1'b1);
    checkOutput("reen_y", y_pos, 12'd0);

`ifdef WIN_PRIORITY_EN
    // 6: overlapping windows; the overlap is owned by window 0
    applyStimulus(2'b11, 2, 3, 4, 3, 3, 5, 4, 3);
    runCycles(FTOT + 10);
    clearStats();
    runCycles(FTOT);
    checkOutput("pri_overlap_id0", cnt_ov0, 4);
    checkOutput("pri_id1", cnt_id1, 8);
    checkOutput("pri_hits", cnt_hit, 20);
`endif

    // Asynchronous reset mid-frame clears outputs at once and disables all windows
    syncFrame();
    runCycles(100);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_full", de_full, 1'b0);
    checkOutput("arst_x", x_pos, 12'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    runCycles(1);
    checkOutput("arst_sof", sof, 1'b1);
    clearStats();
    runCycles(FTOT);
    checkOutput("arst_no_win", cnt0 + cnt1, 0);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
